// File: rtl/key_hit_judge.sv
// key_hit_judge
//   Player-side judge for the LED reaction game. Raw active-low keys are
//   synchronized and debounced. Each player chord is collected over a fixed
//   window and compared against the lit LED target. Every target window is
//   judged as a hit or a miss, and a 2-digit BCD score is kept for the HEX
//   display.
//
// Ports
//   clk          system clock (CLOCK_50)
//   resetn       synchronous, active-low reset
//   keys_n[3:0]  raw KEY inputs, active-low, asynchronous to clk
//   led_target   LED pattern currently lit
//   new_target   one-cycle strobe: led_target carries a new pattern
//   judge_enable high while the game is in the play state
//   score_1s     BCD ones digit of the score
//   score_10s    BCD tens digit of the score
//   hit_pulse    one-cycle pulse per hit
//   miss_pulse   one-cycle pulse per miss
//   judge_state  current FSM state (IDLE=0, ARMED=1, CHORD=2, JUDGED=3)
//
// Optional build macro
//   KH_MISS_PENALTY_EN  when defined, each miss also decrements the score
//                       (floor 00). When undefined, misses never touch the
//                       score.
module key_hit_judge #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CHORD_CYCLES    = 2500000,
  parameter int CNT_W           = 22
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] keys_n,
  input  logic [3:0] led_target,
  input  logic       new_target,
  input  logic       judge_enable,
  output logic [3:0] score_1s,
  output logic [3:0] score_10s,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [1:0] judge_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    CHORD  = 2'd2,
    JUDGED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHORD_LAST = CNT_W'(CHORD_CYCLES - 1);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [CNT_W-1:0] deb_cnt [4];
  logic [3:0]       deb_level;
  logic [3:0]       press_edge;

  state_t           state;
  state_t           state_d;
  logic [3:0]       target;
  logic [3:0]       target_d;
  logic [3:0]       mask;
  logic [3:0]       mask_d;
  logic [CNT_W-1:0] chord_cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       judged_mask;
  logic             retarget;
  logic             hit;
  logic             miss;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= keys_n;
      sync2 <= sync1;
    end
  end

  // Per-key debouncer. The debounced level changes on the DEBOUNCE_CYCLES-th
  // consecutive cycle in which the synced input disagrees with it. Any cycle
  // of agreement restarts the count. press_edge is registered at that same
  // update, but only for released-to-pressed changes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        deb_cnt[i] <= '0;
      end
      deb_level  <= 4'hF;
      press_edge <= 4'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != deb_level[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb_level[i]  <= sync2[i];
            deb_cnt[i]    <= '0;
            press_edge[i] <= ~sync2[i];
          end else begin
            deb_cnt[i]    <= deb_cnt[i] + 1'b1;
            press_edge[i] <= 1'b0;
          end
        end else begin
          deb_cnt[i]    <= '0;
          press_edge[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      target    <= 4'h0;
      mask      <= 4'h0;
      chord_cnt <= '0;
    end else begin
      state     <= state_d;
      target    <= target_d;
      mask      <= mask_d;
      chord_cnt <= cnt_d;
    end
  end

  // Next-state and judgement. The window ends in the CHORD cycle where
  // chord_cnt equals CHORD_CYCLES-1. That cycle is CHORD_CYCLES cycles after
  // the first press_edge, and its own press edges still count. A new_target
  // that arrives mid-window judges with the mask including this cycle's
  // edges, then re-arms. Only one pulse is emitted per window.
  always_comb begin
    state_d     = state;
    target_d    = target;
    mask_d      = mask;
    cnt_d       = chord_cnt;
    judged_mask = mask | press_edge;
    retarget    = 1'b0;
    hit         = 1'b0;
    miss        = 1'b0;
    if (!judge_enable) begin
      state_d = IDLE;
      mask_d  = 4'h0;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (new_target && (led_target != 4'h0)) begin
            target_d = led_target;
            state_d  = ARMED;
          end
        end
        ARMED: begin
          if (new_target) begin
            miss     = 1'b1;
            retarget = 1'b1;
          end else if (press_edge != 4'h0) begin
            mask_d  = press_edge;
            cnt_d   = '0;
            state_d = CHORD;
          end
        end
        CHORD: begin
          if (new_target) begin
            hit      = (judged_mask == target);
            miss     = (judged_mask != target);
            retarget = 1'b1;
          end else begin
            mask_d = judged_mask;
            if (chord_cnt == CHORD_LAST) begin
              hit     = (judged_mask == target);
              miss    = (judged_mask != target);
              state_d = JUDGED;
            end else begin
              cnt_d = chord_cnt + 1'b1;
            end
          end
        end
        JUDGED: begin
          if (new_target) begin
            retarget = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (retarget) begin
        target_d = led_target;
        mask_d   = 4'h0;
        cnt_d    = '0;
        state_d  = (led_target != 4'h0) ? ARMED : IDLE;
      end
    end
  end

  // Pulses are combinational so that a new_target judgement appears in its
  // own cycle. Gating with resetn gives reset priority over a judgement.
  assign hit_pulse   = hit & resetn;
  assign miss_pulse  = miss & resetn;
  assign judge_state = state;

  // BCD score: saturates at 99. With the penalty build, misses decrement it
  // and it floors at 00. hit and miss are mutually exclusive.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      score_1s  <= 4'd0;
      score_10s <= 4'd0;
    end else if (hit && !((score_10s == 4'd9) && (score_1s == 4'd9))) begin
      if (score_1s == 4'd9) begin
        score_1s  <= 4'd0;
        score_10s <= score_10s + 4'd1;
      end else begin
        score_1s <= score_1s + 4'd1;
      end
    end
`ifdef KH_MISS_PENALTY_EN
    else if (miss && !((score_10s == 4'd0) && (score_1s == 4'd0))) begin
      if (score_1s == 4'd0) begin
        score_1s  <= 4'd9;
        score_10s <= score_10s - 4'd1;
      end else begin
        score_1s <= score_1s - 4'd1;
      end
    end
`else
`endif
  end

endmodule

// File: tb/tb_key_hit_judge.sv
// tb_key_hit_judge
//   Directed bench for key_hit_judge with DEBOUNCE_CYCLES=4, CHORD_CYCLES=8.
//   Inputs change 1 time unit after a rising edge. Outputs are sampled on the
//   falling edge. With a key pressed at posedge E0, press_edge is high after
//   E6, and the window judgement is visible at the falling edge after E14.
module tb_key_hit_judge;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] keys_n;
  logic [3:0] led_target;
  logic       new_target;
  logic       judge_enable;
  logic [3:0] score_1s;
  logic [3:0] score_10s;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [1:0] judge_state;

  int total = 0;
  int bad   = 0;
  int exp_score = 0;

  typedef struct {
    logic [3:0] target;
    logic [3:0] first_keys;
    logic [3:0] second_keys;
    int         second_delay;
    bit         expect_hit;
  } vec_t;

  vec_t vecs [9];

  key_hit_judge #(
    .DEBOUNCE_CYCLES(4),
    .CHORD_CYCLES(8),
    .CNT_W(22)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .keys_n(keys_n),
    .led_target(led_target),
    .new_target(new_target),
    .judge_enable(judge_enable),
    .score_1s(score_1s),
    .score_10s(score_10s),
    .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse),
    .judge_state(judge_state)
  );

  always #5 clk = ~clk;

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic int score_bcd();
    return int'({score_10s, score_1s});
  endfunction

  // Reference score model: saturate at 99, optional miss penalty with floor 00.
  function automatic int model(input int s, input bit was_hit, input bit was_miss);
    int r;
    r = s;
    if (was_hit) r = (s == 99) ? 99 : s + 1;
`ifdef KH_MISS_PENALTY_EN
    if (was_miss) r = (s == 0) ? 0 : s - 1;
`else
    if (was_miss) r = s;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] pressed, input logic nt, input logic [3:0] tgt);
    @(posedge clk);
    #1;
    keys_n     = ~pressed;
    new_target = nt;
    led_target = tgt;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'h0, 1'b0, led_target);
  endtask

  // Holds first_keys from E0 on, and adds second_keys from E<delay> on.
  // Returns the pulse counts and the index k of the first pulse.
  task automatic runWindow(input logic [3:0] tgt, input logic [3:0] first, input logic [3:0] second,
                           input int delay, input int cycles,
                           output int hits, output int misses, output int pulse_at);
    logic [3:0] pressed;
    hits = 0;
    misses = 0;
    pulse_at = -1;
    applyStimulus(first, 1'b0, tgt);
    for (int k = 1; k <= cycles; k++) begin
      pressed = first;
      if (delay > 0 && k >= delay) pressed = first | second;
      applyStimulus(pressed, 1'b0, tgt);
      @(negedge clk);
      if (hit_pulse) hits++;
      if (miss_pulse) misses++;
      if ((hit_pulse || miss_pulse) && pulse_at < 0) pulse_at = k;
    end
  endtask

  task automatic judgeOnce(input string tag, input logic [3:0] tgt, input logic [3:0] first,
                           input logic [3:0] second, input int delay, input bit expect_hit,
                           input bit detailed, output int got_hits);
    int h, m, at;
    settle(8);
    applyStimulus(4'h0, 1'b1, tgt);
    @(negedge clk);
    if (detailed) checkOutput({tag, "_nt_quiet"}, int'(hit_pulse | miss_pulse), 0);
    runWindow(tgt, first, second, delay, 20, h, m, at);
    got_hits = h;
    exp_score = model(exp_score, expect_hit, !expect_hit);
    if (detailed) begin
      checkOutput({tag, "_hits"}, h, int'(expect_hit));
      checkOutput({tag, "_misses"}, m, int'(!expect_hit));
      checkOutput({tag, "_pulse_cycle"}, at, 14);
      checkOutput({tag, "_score"}, score_bcd(), to_bcd(exp_score));
    end
  endtask

  initial begin
    int h, m, cnt, sum;

    vecs[0] = '{4'b0010, 4'b0010, 4'b0000, 0, 1'b1};
    vecs[1] = '{4'b0101, 4'b0001, 4'b0100, 3, 1'b1};
    vecs[2] = '{4'b0101, 4'b0001, 4'b0000, 0, 1'b0};
    vecs[3] = '{4'b0101, 4'b0111, 4'b0000, 0, 1'b0};
    vecs[4] = '{4'b1001, 4'b1001, 4'b0000, 0, 1'b1};
    vecs[5] = '{4'b1111, 4'b1111, 4'b0000, 0, 1'b1};
    vecs[6] = '{4'b0110, 4'b0010, 4'b1000, 2, 1'b0};
    vecs[7] = '{4'b0110, 4'b0100, 4'b0010, 8, 1'b1};
    vecs[8] = '{4'b0110, 4'b0100, 4'b0010, 9, 1'b0};

    resetn = 1'b0;
    keys_n = 4'hF;
    led_target = 4'h0;
    new_target = 1'b0;
    judge_enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_score", score_bcd(), 0);
    checkOutput("reset_state", int'(judge_state), 0);
    checkOutput("reset_pulses", int'({hit_pulse, miss_pulse}), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // A zero target in IDLE is not a window.
    applyStimulus(4'h0, 1'b1, 4'h0);
    @(negedge clk);
    checkOutput("zero_tgt_pulse", int'(hit_pulse | miss_pulse), 0);
    applyStimulus(4'h0, 1'b0, 4'h0);
    @(negedge clk);
    checkOutput("zero_tgt_state", int'(judge_state), 0);

    for (int i = 0; i < 9; i++) begin
      judgeOnce($sformatf("vec%0d", i), vecs[i].target, vecs[i].first_keys, vecs[i].second_keys,
                vecs[i].second_delay, vecs[i].expect_hit, 1'b1, h);
    end

    // Bouncing KEY3: 2-cycle runs never satisfy the debouncer.
    settle(8);
    applyStimulus(4'h0, 1'b1, 4'b1000);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(((k / 2) % 2 == 0) ? 4'b1000 : 4'b0000, 1'b0, 4'b1000);
      @(negedge clk);
      cnt += int'(hit_pulse) + int'(miss_pulse);
    end
    checkOutput("bounce_quiet", cnt, 0);
    h = 0;
    m = 0;
    for (int k = 0; k < 30; k++) begin
      applyStimulus(4'b1000, 1'b0, 4'b1000);
      @(negedge clk);
      h += int'(hit_pulse);
      m += int'(miss_pulse);
    end
    exp_score = model(exp_score, 1'b1, 1'b0);
    checkOutput("bounce_hits", h, 1);
    checkOutput("bounce_misses", m, 0);
    checkOutput("bounce_score", score_bcd(), to_bcd(exp_score));

    // new_target while ARMED with no press: immediate miss, re-armed.
    settle(8);
    applyStimulus(4'h0, 1'b1, 4'b0100);
    settle(3);
    applyStimulus(4'h0, 1'b1, 4'b0001);
    @(negedge clk);
    checkOutput("armed_nt_miss", int'(miss_pulse), 1);
    checkOutput("armed_nt_hit", int'(hit_pulse), 0);
    exp_score = model(exp_score, 1'b0, 1'b1);
    applyStimulus(4'h0, 1'b0, 4'b0001);
    @(negedge clk);
    checkOutput("armed_nt_state", int'(judge_state), 1);
    runWindow(4'b0001, 4'b0001, 4'h0, 0, 20, h, m, cnt);
    exp_score = model(exp_score, 1'b1, 1'b0);
    checkOutput("rearmed_hits", h, 1);
    checkOutput("rearmed_misses", m, 0);
    checkOutput("rearmed_score", score_bcd(), to_bcd(exp_score));

    // new_target while CHORD with the correct mask: one hit, then ARMED.
    settle(8);
    applyStimulus(4'h0, 1'b1, 4'b0010);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'b0010, 1'b0, 4'b0010);
      @(negedge clk);
      cnt += int'(hit_pulse) + int'(miss_pulse);
    end
    checkOutput("chord_pre_quiet", cnt, 0);
    applyStimulus(4'b0010, 1'b1, 4'b0100);
    @(negedge clk);
    checkOutput("chord_nt_hit", int'(hit_pulse), 1);
    checkOutput("chord_nt_miss", int'(miss_pulse), 0);
    exp_score = model(exp_score, 1'b1, 1'b0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(4'b0010, 1'b0, 4'b0100);
      @(negedge clk);
      if (k == 0) checkOutput("chord_nt_state", int'(judge_state), 1);
      cnt += int'(hit_pulse) + int'(miss_pulse);
    end
    checkOutput("chord_nt_no_double", cnt, 0);
    checkOutput("chord_nt_score", score_bcd(), to_bcd(exp_score));
    applyStimulus(4'b0010, 1'b0, 4'b0100);
    judge_enable = 1'b0;
    applyStimulus(4'b0010, 1'b0, 4'b0100);
    judge_enable = 1'b1;

    // Preload to 98, then saturate at 99.
    sum = 0;
    cnt = 0;
    while (exp_score < 98) begin
      judgeOnce("preload", 4'b0001, 4'b0001, 4'h0, 0, 1'b1, 1'b0, h);
      sum += h;
      cnt++;
    end
    checkOutput("preload_hits", sum, cnt);
    checkOutput("preload_score", score_bcd(), to_bcd(98));
    judgeOnce("to99", 4'b0001, 4'b0001, 4'h0, 0, 1'b1, 1'b1, h);
    judgeOnce("sat99", 4'b0001, 4'b0001, 4'h0, 0, 1'b1, 1'b1, h);
    judgeOnce("miss_at99", 4'b0001, 4'b0010, 4'h0, 0, 1'b0, 1'b1, h);

    // judge_enable dropped in the judgement cycle: no pulse, IDLE, score held.
    settle(8);
    applyStimulus(4'h0, 1'b1, 4'b0001);
    cnt = 0;
    for (int k = 0; k < 14; k++) begin
      applyStimulus(4'b0001, 1'b0, 4'b0001);
      @(negedge clk);
      cnt += int'(hit_pulse) + int'(miss_pulse);
    end
    checkOutput("en_pre_quiet", cnt, 0);
    applyStimulus(4'b0001, 1'b0, 4'b0001);
    judge_enable = 1'b0;
    @(negedge clk);
    checkOutput("en_drop_pulse", int'(hit_pulse | miss_pulse), 0);
    applyStimulus(4'b0001, 1'b0, 4'b0001);
    @(negedge clk);
    checkOutput("en_drop_state", int'(judge_state), 0);
    checkOutput("en_drop_score", score_bcd(), to_bcd(exp_score));
    judge_enable = 1'b1;

    // resetn asserted in the judgement cycle: no pulse, then IDLE and 00.
    settle(8);
    applyStimulus(4'h0, 1'b1, 4'b0001);
    for (int k = 0; k < 14; k++) applyStimulus(4'b0001, 1'b0, 4'b0001);
    applyStimulus(4'b0001, 1'b0, 4'b0001);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_pulse", int'(hit_pulse | miss_pulse), 0);
    applyStimulus(4'b0001, 1'b0, 4'b0001);
    @(negedge clk);
    checkOutput("rst_mid_state", int'(judge_state), 0);
    checkOutput("rst_mid_score", score_bcd(), 0);
    exp_score = 0;
    applyStimulus(4'h0, 1'b0, 4'b0001);
    resetn = 1'b1;

    // Score floor at 00 and the borrow from 10 (penalty build decrements).
    judgeOnce("miss_at00", 4'b0001, 4'b0010, 4'h0, 0, 1'b0, 1'b1, h);
    for (int i = 0; i < 10; i++) judgeOnce("to10", 4'b0001, 4'b0001, 4'h0, 0, 1'b1, 1'b0, h);
    checkOutput("score_10", score_bcd(), to_bcd(10));
    judgeOnce("miss_at10", 4'b0001, 4'b0010, 4'h0, 0, 1'b0, 1'b1, h);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
